// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : scan_decoder
// Brief    : Free-running scan position counter with programmable wrap, direction,
//            dwell and load, driving a registered active-low 1-of-2^SEL_W decoder.
// Revision : 1.0
// ============================================================================
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_b0,
    input  logic                  en_b1,
    input  logic                  en2,
    input  logic                  run,
    input  logic                  dir,
    input  logic [SEL_W-1:0]      last,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  load,
    input  logic [SEL_W-1:0]      load_val,
    output logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   dec_n,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;

    logic [SEL_W-1:0]   r_sel;
    logic [DWELL_W-1:0] r_tick;
    logic [OUT_W-1:0]   r_dec_n;
    logic               r_wrap;

    logic [SEL_W-1:0]   w_sel_next;
    logic [DWELL_W-1:0] w_tick_next;
    logic [OUT_W-1:0]   w_dec_next;
    logic               w_wrap_next;
    logic               w_enabled;

    assign w_enabled = ~en_b0 & ~en_b1 & en2;

    always_comb begin
        w_sel_next  = r_sel;
        w_tick_next = r_tick;
        w_wrap_next = 1'b0;
        if (load) begin
            w_sel_next  = load_val;
            w_tick_next = '0;
        end else if (run) begin
            if (r_tick == dwell) begin
                w_tick_next = '0;
                if (!dir) begin
                    if (r_sel >= last) begin
                        w_sel_next  = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_sel_next = r_sel + 1'b1;
                    end
                end else begin
                    // A position above the wrap point (reachable only by load)
                    // snaps back to last without counting as a wrap.
                    if (r_sel == '0) begin
                        w_sel_next  = last;
                        w_wrap_next = 1'b1;
                    end else if (r_sel > last) begin
                        w_sel_next = last;
                    end else begin
                        w_sel_next = r_sel - 1'b1;
                    end
                end
            end else begin
                w_tick_next = r_tick + 1'b1;
            end
        end
    end

    // Decode the position being entered so dec_n and sel always agree.
    assign w_dec_next = w_enabled ? ~(OUT_W'(1) << w_sel_next) : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_tick  <= '0;
            r_dec_n <= '1;
            r_wrap  <= 1'b0;
        end else begin
            r_sel   <= w_sel_next;
            r_tick  <= w_tick_next;
            r_dec_n <= w_dec_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign sel   = r_sel;
    assign dec_n = r_dec_n;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_decoder
// Brief    : Scoreboard bench for scan_decoder (SEL_W=3 and SEL_W=4 instances).
// Revision : 1.0
// ============================================================================
module tb_scan_decoder;

    typedef struct {
        int          id;
        logic [3:0]  sel;
        logic [15:0] dec;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SEL_W=3, DWELL_W=8
    logic       rst_a, en_b0, en_b1, en2, run_a, dir_a, load_a;
    logic [2:0] last_a, load_val_a, sel_a;
    logic [7:0] dwell_a, dec_a;
    logic       wrap_a;

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .en_b0(en_b0), .en_b1(en_b1), .en2(en2),
        .run(run_a), .dir(dir_a), .last(last_a), .dwell(dwell_a),
        .load(load_a), .load_val(load_val_a),
        .sel(sel_a), .dec_n(dec_a), .wrap(wrap_a)
    );

    // Instance B: SEL_W=4, DWELL_W=2
    logic        rst_b;
    logic [3:0]  sel_b;
    logic [15:0] dec_b;
    logic        wrap_b;

    scan_decoder #(.SEL_W(4), .DWELL_W(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .en_b0(1'b0), .en_b1(1'b0), .en2(1'b1),
        .run(1'b1), .dir(1'b0), .last(4'd15), .dwell(2'd3),
        .load(1'b0), .load_val(4'd0),
        .sel(sel_b), .dec_n(dec_b), .wrap(wrap_b)
    );

    function automatic logic [7:0] oh8(input int s);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << s);
    endfunction

    // Wait for the next edge, then record what instance A must show after it.
    task automatic exp_a(input string nm, input int s, input logic [7:0] d, input logic w);
        @(posedge clk);
        #1;
        q.push_back('{0, 4'(s), {8'h00, d}, w, nm});
    endtask

    task automatic exp_b(input string nm, input int s, input logic [15:0] d, input logic w);
        @(posedge clk);
        #1;
        q.push_back('{1, 4'(s), d, w, nm});
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [3:0]  as;
            logic [15:0] ad;
            logic        aw;
            e = q.pop_front();
            if (e.id == 0) begin
                as = {1'b0, sel_a};
                ad = {8'h00, dec_a};
                aw = wrap_a;
            end else begin
                as = sel_b;
                ad = dec_b;
                aw = wrap_b;
            end
            n_checks++;
            if (as === e.sel && ad === e.dec && aw === e.wrap)
                n_pass++;
            else
                $display("FAIL %s: got sel=%0d dec_n=%h wrap=%b, want sel=%0d dec_n=%h wrap=%b",
                         e.name, as, ad, aw, e.sel, e.dec, e.wrap);
        end
    end

    initial begin
        int seq_dn [7] = '{5, 4, 3, 2, 1, 0, 5};
        rst_a = 1'b1; rst_b = 1'b1;
        en_b0 = 1'b0; en_b1 = 1'b0; en2 = 1'b1;
        run_a = 1'b1; dir_a = 1'b0; last_a = 3'd7; dwell_a = 8'd0;
        load_a = 1'b0; load_val_a = 3'd0;

        // Reset dominates run and the enables
        exp_a("reset_a", 0, 8'hFF, 1'b0);
        exp_b("reset_b", 0, 16'hFFFF, 1'b0);

        // Up count, last=7, dwell=0
        rst_a = 1'b0;
        for (int k = 1; k <= 8; k++)
            exp_a("up8", k % 8, oh8(k % 8), k == 8);

        // dwell=2, last=4: each position held 3 cycles, one wrap per 15
        dwell_a = 8'd2; last_a = 3'd4;
        for (int k = 1; k <= 15; k++)
            exp_a("dwell3", (k / 3) % 5, oh8((k / 3) % 5), k == 15);

        // Pause mid-dwell: tick freezes at 1 and resumes from there
        exp_a("pause_pre", 0, 8'hFE, 1'b0);
        run_a = 1'b0;
        for (int k = 0; k < 3; k++)
            exp_a("pause_hold", 0, 8'hFE, 1'b0);
        run_a = 1'b1;
        exp_a("pause_resume", 0, 8'hFE, 1'b0);
        exp_a("pause_step", 1, 8'hFD, 1'b0);

        // Down count, last=5, starting from a loaded 0
        dir_a = 1'b1; last_a = 3'd5; dwell_a = 8'd0;
        load_a = 1'b1; load_val_a = 3'd0;
        exp_a("load0", 0, 8'hFE, 1'b0);
        load_a = 1'b0;
        for (int k = 0; k < 7; k++)
            exp_a("down", seq_dn[k], oh8(seq_dn[k]), k == 0 || k == 6);

        // Load above last, then step down snaps to last without wrap
        load_a = 1'b1; load_val_a = 3'd7;
        exp_a("load_above", 7, 8'h7F, 1'b0);
        load_a = 1'b0;
        exp_a("snap_last", 5, 8'hDF, 1'b0);
        exp_a("down_after_snap", 4, 8'hEF, 1'b0);

        // Enables toggled one at a time while scanning up
        dir_a = 1'b0; last_a = 3'd7;
        exp_a("en_on", 5, 8'hDF, 1'b0);
        en_b0 = 1'b1; exp_a("en_b0_off", 6, 8'hFF, 1'b0);
        en_b0 = 1'b0; exp_a("en_b0_on", 7, 8'h7F, 1'b0);
        en_b1 = 1'b1; exp_a("en_b1_off", 0, 8'hFF, 1'b1);
        en_b1 = 1'b0; exp_a("en_b1_on", 1, 8'hFD, 1'b0);
        en2 = 1'b0;   exp_a("en2_off", 2, 8'hFF, 1'b0);
        en2 = 1'b1;   exp_a("en2_on", 3, 8'hF7, 1'b0);

        // Load coincident with tick==dwell and sel==last
        dwell_a = 8'd1;
        load_a = 1'b1; load_val_a = 3'd7;
        exp_a("load7", 7, 8'h7F, 1'b0);
        load_a = 1'b0;
        exp_a("tick_to_dwell", 7, 8'h7F, 1'b0);
        load_a = 1'b1; load_val_a = 3'd3;
        exp_a("load_wins", 3, 8'hF7, 1'b0);
        load_a = 1'b0;
        exp_a("tick_cleared", 3, 8'hF7, 1'b0);
        exp_a("step_after_load", 4, 8'hEF, 1'b0);

        // Reset wins over load
        rst_a = 1'b1; load_a = 1'b1; load_val_a = 3'd5;
        exp_a("rst_over_load", 0, 8'hFF, 1'b0);
        rst_a = 1'b0; load_a = 1'b0;
        exp_a("post_rst_hold", 0, 8'hFE, 1'b0);
        exp_a("post_rst_step", 1, 8'hFD, 1'b0);

        // Instance B: 16 positions, dwell 3, one wrap per 64 cycles
        rst_b = 1'b0;
        for (int k = 1; k <= 64; k++)
            exp_b("wide_scan", (k / 4) % 16, ~(16'(1) << ((k / 4) % 16)), k == 64);

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
# scan_decoder

Parametrised scanning line decoder: a free-running position counter with programmable wrap point, direction, dwell time and load, driving a registered active-low 1-of-2^SEL_W decoder gated by three 138-style enables. It is the sequential successor to the fixed 3-to-8 decoder and mod-8 counter pair. It sits between the control logic and multiplexed loads such as display digits or keypad rows, and advances the active line autonomously.

## Interface
- SEL_W, 3, position width; decoder output width OUT_W = 2**SEL_W
- DWELL_W, 8, width of dwell (cycles-per-position) field
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high; highest priority
- en_b0  in  1  active-low enable; 1 forces all outputs inactive
- en_b1  in  1  active-low enable; 1 forces all outputs inactive
- en2  in  1  active-high enable; 0 forces all outputs inactive
- run  in  1  1 = scanning advances; 0 = position and dwell counter hold
- dir  in  1  0 = up, 1 = down
- last  in  SEL_W  highest position in the scan (wrap point)
- dwell  in  DWELL_W  cycles per position minus 1 (0 = step every cycle)
- load  in  1  1-cycle load strobe
- load_val  in  SEL_W  position to load
- sel  out  SEL_W  current position (registered)
- dec_n  out  OUT_W  registered active-low one-hot of sel; all ones when disabled
- wrap  out  1  1-cycle pulse on the edge where the position wraps

## Operation
- Reset, sampled on the clk edge: sel = 0, internal tick counter = 0, dec_n = all ones, wrap = 0.
- Enabled condition: en_b0 = 0, en_b1 = 0 and en2 = 1.
- Priority each edge: rst, then load, then step, then hold.
- Load:
  - sel <= load_val and tick <= 0. No step occurs and wrap = 0.
  - load_val > last is accepted as-is.
- Tick counter (run = 1, no load):
  - If tick == dwell: a step occurs and tick <= 0.
  - Otherwise tick <= tick + 1.
  - If dwell is reduced below the current tick, tick keeps counting modulo 2^DWELL_W until it equals dwell. This is a documented, allowed slip.
- Step up (dir = 0):
  - If sel >= last: sel <= 0, wrap <= 1.
  - Otherwise sel <= sel + 1.
- Step down (dir = 1):
  - If sel == 0: sel <= last, wrap <= 1.
  - If sel > last: sel <= last with no wrap.
  - Otherwise sel <= sel - 1.
- last = 0: sel stays at 0 and wrap pulses on every step.
- run = 0: sel and tick hold and wrap = 0. dec_n still tracks the enables.
- Changes to dir, last or dwell are sampled at the edge on which they are used. No step-in-progress state exists beyond tick.
- dec_n next value:
  - Enabled: ~(1 << sel_next), where sel_next is the value sel takes at this edge.
  - Disabled: all ones.
  - dec_n therefore always agrees with sel in the same cycle while enabled.
- At most one dec_n bit is low in any cycle. dec_n is glitch-free because it is driven from flops.

## Timing
- sel, dec_n and wrap all update on the same rising edge. All outputs are registered.
- Position dwell: each position is held for dwell+1 cycles while run = 1 and no load occurs.
- A full up-scan lasts (last+1)*(dwell+1) cycles. wrap fires once per scan, on the edge entering 0 (up) or entering last (down).
- Enable-to-dec_n latency is 1 cycle: enables sampled at edge k take effect on dec_n after edge k.
- load to sel/dec_n latency is 1 cycle. The first step after a load occurs dwell+1 cycles later.
- Reset asserted mid-scan: the next edge forces the reset values regardless of load or run. The first step after reset release comes dwell+1 edges later, provided run = 1.
- Simultaneous load and tick == dwell: load wins and there is no wrap.
- Simultaneous load and rst: rst wins.

## Test plan
- Reset, then run=1, dir=0, last=7, dwell=0, all enabled -> sel counts 0,1,…,7,0 on consecutive cycles; dec_n steps 8'hFE,8'hFD,…,8'h7F,8'hFE; wrap is high exactly on the 7->0 edge.
- dwell=2, last=4, up -> each sel is held 3 cycles; sel returns to 0 after 15 cycles with a single wrap pulse; with run=0 mid-dwell, sel and tick freeze and resume from the same tick.
- dir=1, last=5, starting from sel=0 -> sequence 5,4,3,2,1,0,5 with wrap on the 0->5 edge; load_val=7 while last=5, then step down -> sel goes 7->5 with wrap=0.
- Toggle enables one at a time (en_b0=1, then en_b1=1, then en2=0) while scanning -> dec_n = 8'hFF one cycle after each disabling edge while sel keeps advancing; re-enabling restores the correct one-hot one cycle later.
- load=1 with load_val=3 coincident with tick==dwell and sel==last -> sel=3, wrap=0, tick=0; rst=1 together with load -> sel=0, dec_n=8'hFF.
- SEL_W=4, DWELL_W=2, last=15, dwell=3 -> 16-bit dec_n scans 16'hFFFE…16'h7FFF, each position held 4 cycles, one wrap per 64 cycles.
